// File: rtl/ntt_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ntt_op_sequencer_pkg
// Brief    : Op codes, FSM states and helpers shared by the NTT op sequencer.
// Revision : 1.0
// ============================================================================
package ntt_op_sequencer_pkg;

    localparam int OP_W   = 3;
    localparam int PASS_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NTT  = 3'd0,
        OP_INTT = 3'd1,
        OP_PWM  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_SUB;
    endfunction

    // Element-wise ops interleave an A and a B word per result word.
    function automatic logic op_is_dual(input logic [OP_W-1:0] op);
        return (op >= OP_PWM) && (op <= OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ntt_op_sequencer_if
// Brief    : Command handshake, RAM strobes and datapath controls of the sequencer.
// Revision : 1.0
// ============================================================================
interface ntt_op_sequencer_if #(
    parameter int ADDR_W = 8
);
    import ntt_op_sequencer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [OP_W-1:0]   bu_op;
    logic [PASS_W-1:0] bu_pass;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, abort,
        input  cmd_ready, rd_en, rd_addr, rd_sel, wr_en, wr_addr,
        input  bu_op, bu_pass, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, abort,
        output cmd_ready, rd_en, rd_addr, rd_sel, wr_en, wr_addr,
        output bu_op, bu_pass, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/ntt_op_sequencer_delay.sv
`default_nettype none
// ============================================================================
// Module   : ntt_op_sequencer_delay
// Brief    : DEPTH-stage shift register with synchronous flush (write pipe).
// Revision : 1.0
// ============================================================================
module ntt_op_sequencer_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            stage_q <= '0;
        end else begin
            for (int s = DEPTH - 1; s > 0; s--) begin
                stage_q[s] <= stage_q[s-1];
            end
            stage_q[0] <= d_i;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ntt_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ntt_op_sequencer
// Brief    : Command FSM driving coefficient-RAM addresses for NTT/INTT/PWM/ADD/SUB.
// Revision : 1.0
// ============================================================================
module ntt_op_sequencer
    import ntt_op_sequencer_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int COEF_W = 12,
    parameter int N      = 256,
    parameter int PASSES = 7,
    parameter int ADDR_W = 8,
    parameter int BU_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    ntt_op_sequencer_if.slave bus
);

    localparam int c_words = N / LANES;
    localparam int c_cnt_w = $clog2(2 * c_words + BU_LAT + 1);

    generate
        if (COEF_W < 1 || BU_LAT < 1 || PASSES < 1 || PASSES > 8 || (N % LANES) != 0) begin : g_bad_params
            $error("ntt_op_sequencer: illegal parameter set");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   src_a_q, src_a_d;
    logic [ADDR_W-1:0]   src_b_q, src_b_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                err_q, err_d;

    logic                w_fire;
    logic                w_dual;
    logic                w_rd_en;
    logic                w_rd_sel;
    logic                w_push;
    logic [c_cnt_w-1:0]  w_last_rd;
    logic [ADDR_W-1:0]   w_idx;
    logic [ADDR_W-1:0]   w_rd_base;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W:0]     w_pipe_in;
    logic [ADDR_W:0]     w_pipe_out;

    assign w_fire    = bus.cmd_valid && bus.cmd_ready && !bus.abort;
    assign w_dual    = op_is_dual(op_q);
    assign w_last_rd = w_dual ? c_cnt_w'(2 * c_words - 1) : c_cnt_w'(c_words - 1);

    // Dual-operand reads step the word index every second cycle (A then B).
    assign w_idx     = ADDR_W'(w_dual ? (cnt_q >> 1) : cnt_q);
    assign w_rd_en   = (state_q == S_READ);
    assign w_rd_sel  = w_dual && cnt_q[0];
    assign w_rd_base = w_rd_sel ? src_b_q :
                       ((w_dual || pass_q == '0) ? src_a_q : dst_q);
    assign w_wr_addr = dst_q + w_idx;
    assign w_push    = w_rd_en && (!w_dual || cnt_q[0]);
    assign w_pipe_in = {w_push, w_push ? w_wr_addr : {ADDR_W{1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        op_d    = op_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        dst_d   = dst_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_fire) begin
                    if (op_is_legal(bus.cmd_op)) begin
                        state_d = S_READ;
                        op_d    = bus.cmd_op;
                        src_a_d = bus.cmd_src_a;
                        src_b_d = bus.cmd_src_b;
                        dst_d   = bus.cmd_dst;
                        cnt_d   = '0;
                        pass_d  = '0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == w_last_rd) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Hold reads until the last write of this pass has landed.
                if (cnt_q == c_cnt_w'(BU_LAT - 1)) begin
                    cnt_d = '0;
                    if (!w_dual && pass_q != PASS_W'(PASSES - 1)) begin
                        pass_d  = pass_q + 1'b1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pass_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pass_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pass_q  <= '0;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            op_q    <= op_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
        end
    end

    ntt_op_sequencer_delay #(
        .DEPTH (BU_LAT),
        .WIDTH (ADDR_W + 1)
    ) u_wr_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.abort),
        .d_i     (w_pipe_in),
        .q_o     (w_pipe_out)
    );

    assign bus.cmd_ready = (state_q == S_IDLE) && rst;
    assign bus.rd_en     = w_rd_en;
    assign bus.rd_addr   = w_rd_base + w_idx;
    assign bus.rd_sel    = w_rd_sel;
    assign bus.wr_en     = w_pipe_out[ADDR_W];
    assign bus.wr_addr   = w_pipe_out[ADDR_W-1:0];
    assign bus.bu_op     = op_q;
    assign bus.bu_pass   = pass_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE) && !bus.abort;
    assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_op_sequencer
// Brief    : Directed bench for the NTT op sequencer (default and LANES=4/BU_LAT=5).
// Revision : 1.0
// ============================================================================
module tb_ntt_op_sequencer;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;
    int   done_at;

    always #5 clk = ~clk;

    ntt_op_sequencer_if #(.ADDR_W(AW)) bus_a ();
    ntt_op_sequencer_if #(.ADDR_W(AW)) bus_b ();

    ntt_op_sequencer #(
        .LANES(8), .COEF_W(12), .N(256), .PASSES(7), .ADDR_W(AW), .BU_LAT(3)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    ntt_op_sequencer #(
        .LANES(4), .COEF_W(12), .N(256), .PASSES(7), .ADDR_W(AW), .BU_LAT(5)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // {ready, err, busy, done, op[2:0], pass[2:0], rd_en, rd_sel, rd_addr, wr_en, wr_addr}
    function automatic logic [31:0] mk(input logic rdy, input logic er, input logic bsy,
                                       input logic dn, input logic [2:0] op, input logic [2:0] ps,
                                       input logic re, input logic rs, input logic [7:0] ra,
                                       input logic we, input logic [7:0] wa);
        return {3'b000, rdy, er, bsy, dn, op, ps, re, rs, ra, we, wa};
    endfunction

    function automatic logic [31:0] obs_vec(input bit sel);
        logic [31:0] v;
        if (!sel) begin
            v = mk(bus_a.cmd_ready, bus_a.err, bus_a.busy, bus_a.done, bus_a.bu_op, bus_a.bu_pass,
                   bus_a.rd_en, bus_a.rd_en ? bus_a.rd_sel : 1'b0, bus_a.rd_en ? bus_a.rd_addr : 8'h00,
                   bus_a.wr_en, bus_a.wr_en ? bus_a.wr_addr : 8'h00);
        end else begin
            v = mk(bus_b.cmd_ready, bus_b.err, bus_b.busy, bus_b.done, bus_b.bu_op, bus_b.bu_pass,
                   bus_b.rd_en, bus_b.rd_en ? bus_b.rd_sel : 1'b0, bus_b.rd_en ? bus_b.rd_addr : 8'h00,
                   bus_b.wr_en, bus_b.wr_en ? bus_b.wr_addr : 8'h00);
        end
        return v;
    endfunction

    // Expected outputs in cycle c, where cycle 0 is the handshake cycle.
    function automatic logic [31:0] exp_vec(input logic [2:0] op, input int c, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] d,
                                            input int w, input int l, input int p);
        bit         two;
        int         per, last, pass, j, wc;
        logic       re, rs, we;
        logic [7:0] ra, wa;
        logic [2:0] ps;
        re = 1'b0; rs = 1'b0; we = 1'b0; ra = 8'h00; wa = 8'h00; ps = 3'd0;
        two = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        if (two) begin
            last = 2 * w + l + 1;
            if (c - 1 < 2 * w) begin
                re = 1'b1;
                rs = ((c - 1) % 2) == 1;
                ra = (rs ? b : a) + 8'((c - 1) / 2);
            end
            wc = c - l;
            if (wc >= 1 && wc - 1 < 2 * w && ((wc - 1) % 2) == 1) begin
                we = 1'b1;
                wa = d + 8'((wc - 1) / 2);
            end
        end else begin
            per  = w + l;
            last = p * per + 1;
            pass = (c - 1) / per;
            j    = (c - 1) % per;
            if (c <= last) ps = 3'((pass < p) ? pass : p - 1);
            if (pass < p && j < w) begin
                re = 1'b1;
                ra = ((pass == 0) ? a : d) + 8'(j);
            end
            wc = c - l;
            if (wc >= 1 && (wc - 1) / per < p && (wc - 1) % per < w) begin
                we = 1'b1;
                wa = d + 8'((wc - 1) % per);
            end
        end
        return mk(!(c <= last), 1'b0, c <= last, c == last, op, ps, re, rs, ra, we, wa);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input bit sel, input logic v, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] d, input logic ab);
        if (!sel) begin
            bus_a.cmd_valid = v; bus_a.cmd_op = op; bus_a.cmd_src_a = a;
            bus_a.cmd_src_b = b; bus_a.cmd_dst = d; bus_a.abort = ab;
        end else begin
            bus_b.cmd_valid = v; bus_b.cmd_op = op; bus_b.cmd_src_a = a;
            bus_b.cmd_src_b = b; bus_b.cmd_dst = d; bus_b.abort = ab;
        end
    endtask

    task automatic issue(input bit sel, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d, input string tag);
        logic [31:0] o;
        @(negedge clk);
        set_in(sel, 1'b1, op, a, b, d, 1'b0);
        #1;
        o = obs_vec(sel);
        chk({tag, "_ready"}, {31'd0, o[28]}, 32'd1);
    endtask

    task automatic follow(input bit sel, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] d, input int w, input int l,
                          input int p, input int c_to, input logic hold, input string tag,
                          output int first_done);
        logic [31:0] o;
        first_done = 0;
        for (int c = 1; c <= c_to; c++) begin
            @(negedge clk);
            if (!sel) bus_a.cmd_valid = hold;
            else      bus_b.cmd_valid = hold;
            #1;
            o = obs_vec(sel);
            if (o[25] && first_done == 0) first_done = c;
            chk($sformatf("%s_c%0d", tag, c), o, exp_vec(op, c, a, b, d, w, l, p));
        end
    endtask

    initial begin
        set_in(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);

        // Reset: cmd_ready low while rst is low, everything zero afterwards
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready_low", {31'd0, bus_a.cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_outputs", obs_vec(1'b0), mk(1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
        chk("rst_addrs", {16'd0, bus_a.rd_addr, bus_a.wr_addr}, 32'd0);

        // NTT, src_a=0x00, dst=0x40
        issue(1'b0, 3'd0, 8'h00, 8'h00, 8'h40, "ntt");
        follow(1'b0, 3'd0, 8'h00, 8'h00, 8'h40, 32, 3, 7, 247, 1'b0, "ntt", done_at);
        chk("ntt_done_cycle", done_at, 32'd246);

        // ADD, src_a=0x10, src_b=0x30, dst=0x80
        issue(1'b0, 3'd3, 8'h10, 8'h30, 8'h80, "add");
        follow(1'b0, 3'd3, 8'h10, 8'h30, 8'h80, 32, 3, 7, 69, 1'b0, "add", done_at);
        chk("add_done_cycle", done_at, 32'd68);

        // SUB with destination wrapping past 0xFF
        issue(1'b0, 3'd4, 8'h00, 8'h20, 8'hF0, "sub");
        follow(1'b0, 3'd4, 8'h00, 8'h20, 8'hF0, 32, 3, 7, 69, 1'b0, "sub", done_at);
        chk("sub_done_cycle", done_at, 32'd68);

        // Illegal op 6: err one cycle, no RAM access, bu_op keeps SUB
        issue(1'b0, 3'd6, 8'h00, 8'h00, 8'h00, "illegal");
        @(negedge clk);
        bus_a.cmd_valid = 1'b0;
        #1;
        chk("illegal_err", obs_vec(1'b0), mk(1, 1, 0, 0, 3'd4, 3'd0, 0, 0, 8'h00, 0, 8'h00));
        @(negedge clk);
        #1;
        chk("illegal_err_clear", obs_vec(1'b0), mk(1, 0, 0, 0, 3'd4, 3'd0, 0, 0, 8'h00, 0, 8'h00));

        // abort in IDLE blocks acceptance
        @(negedge clk);
        set_in(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 8'h40, 1'b1);
        @(negedge clk);
        set_in(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h40, 1'b0);
        #1;
        chk("idle_abort_blocks", obs_vec(1'b0), mk(1, 0, 0, 0, 3'd4, 3'd0, 0, 0, 8'h00, 0, 8'h00));

        // NTT aborted in pass 2 READ (cycle 76 = pass 2, word 5)
        issue(1'b0, 3'd0, 8'h05, 8'h00, 8'h60, "ntt_ab");
        follow(1'b0, 3'd0, 8'h05, 8'h00, 8'h60, 32, 3, 7, 75, 1'b0, "ntt_ab", done_at);
        @(negedge clk);
        bus_a.abort = 1'b1;
        #1;
        chk("abort_cycle", obs_vec(1'b0), mk(0, 0, 1, 0, 3'd0, 3'd2, 1, 0, 8'h65, 1, 8'h62));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus_a.abort = 1'b0;
            #1;
            chk($sformatf("abort_quiet_%0d", k), obs_vec(1'b0),
                mk(1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
        end

        // PWM after abort completes normally
        issue(1'b0, 3'd2, 8'h00, 8'h80, 8'hC0, "pwm");
        follow(1'b0, 3'd2, 8'h00, 8'h80, 8'hC0, 32, 3, 7, 69, 1'b0, "pwm", done_at);
        chk("pwm_done_cycle", done_at, 32'd68);

        // PWM with cmd_valid held while busy, then a one-cycle reset
        issue(1'b0, 3'd2, 8'h20, 8'h40, 8'h60, "pwm_rst");
        follow(1'b0, 3'd2, 8'h20, 8'h40, 8'h60, 32, 3, 7, 9, 1'b1, "pwm_hold", done_at);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready_low", {31'd0, bus_a.cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_a.cmd_valid = 1'b0;
        #1;
        chk("midrst_outputs", obs_vec(1'b0), mk(1, 0, 0, 0, 3'd0, 3'd0, 0, 0, 8'h00, 0, 8'h00));
        chk("midrst_addrs", {16'd0, bus_a.rd_addr, bus_a.wr_addr}, 32'd0);

        // Parameter sweep: LANES=4 (W=64), BU_LAT=5
        issue(1'b1, 3'd0, 8'h00, 8'h00, 8'h40, "sweep");
        follow(1'b1, 3'd0, 8'h00, 8'h00, 8'h40, 64, 5, 7, 485, 1'b0, "sweep", done_at);
        chk("sweep_done_cycle", done_at, 32'd484);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
